dfe_cfg_master: RTL

//  Configuration bus initiator for the DFE top: drives MTRANS/MWRITE/MSELx/MADDR/MWDATA and samples MRDATA.

---
 rtl/dfe_cfg_master.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dfe_cfg_master.sv
// dfe_cfg_master: config-bus initiator; FIFOs host commands and runs two-phase SETUP/ACCESS transfers.
// Optional write read-back check enabled by defining DFE_CFG_WR_VERIFY_EN. Rev 1.0
`default_nettype none

module dfe_cfg_master #(
  parameter int ADDR_WIDTH  = 7,
  parameter int PDATA_WIDTH = 32,
  parameter int COEFF_WIDTH = 20,
  parameter int COMP        = 4,
  parameter int CMD_DEPTH   = 4,
  parameter int RD_LAT      = 1,
  localparam int SEL_W      = (COMP > 1) ? $clog2(COMP) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [SEL_W-1:0]       cmd_sel,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [COEFF_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PDATA_WIDTH-1:0] rsp_rdata,
  output logic                   MTRANS,
  output logic                   MWRITE,
  output logic [COMP-1:0]        MSELx,
  output logic [ADDR_WIDTH-1:0]  MADDR,
  output logic [COEFF_WIDTH-1:0] MWDATA,
  input  logic [PDATA_WIDTH-1:0] MRDATA,
`ifdef DFE_CFG_WR_VERIFY_EN
  output logic                   verify_err,
`endif
  output logic                   busy,
  output logic                   err_sel
);

  localparam int         c_PTR_W    = $clog2(CMD_DEPTH);
  localparam logic [1:0] c_LAT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  typedef struct packed {
    logic                   write;
    logic [SEL_W-1:0]       sel;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COEFF_WIDTH-1:0] wdata;
  } cmd_t;

`ifdef DFE_CFG_WR_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_RDWAIT, S_RESP, S_VSETUP, S_VACCESS, S_VRDWAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_RDWAIT, S_RESP
  } state_t;
`endif

  // ---------------- command FIFO ----------------
  cmd_t               r_mem [CMD_DEPTH];
  logic [c_PTR_W-1:0] r_wptr, r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_cmd_ready;
  logic               w_push, w_pop, w_empty;
  logic [c_PTR_W:0]   w_count_nxt;
  cmd_t               w_head;
  logic               w_head_ok;
  logic [COMP-1:0]    w_head_onehot;

  assign w_push        = cmd_valid && r_cmd_ready;
  assign w_empty       = (r_count == '0);
  assign w_count_nxt   = r_count + (c_PTR_W+1)'(w_push) - (c_PTR_W+1)'(w_pop);
  assign w_head        = r_mem[r_rptr];
  assign w_head_ok     = (32'(w_head.sel) < COMP);
  assign w_head_onehot = COMP'(1) << w_head.sel;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{cmd_write, cmd_sel, cmd_addr, cmd_wdata};
  end

  // Ready is registered from the next occupancy, so a full FIFO refuses a push even during a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != (c_PTR_W+1)'(CMD_DEPTH));
    end
  end

  // ---------------- transfer sequencer ----------------
  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_lat, w_lat_nxt;
  logic [COMP-1:0]        r_msel, w_msel_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
  logic [COEFF_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                   r_write, w_write_nxt;
  logic                   r_trans, w_trans_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic [PDATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                   r_verr, w_verr_nxt;
  logic                   w_launch, w_mismatch;

  assign w_mismatch = (MRDATA[COEFF_WIDTH-1:0] != r_wdata);

  always_comb begin
    w_state_nxt     = r_state;
    w_lat_nxt       = r_lat;
    w_msel_nxt      = r_msel;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_write_nxt     = r_write;
    w_trans_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_verr_nxt      = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rdata_nxt     = r_rdata;
    w_launch        = 1'b0;
    w_pop           = 1'b0;

    case (r_state)
      S_IDLE:  w_launch = 1'b1;
      S_SETUP: begin
        w_trans_nxt = 1'b1;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_write) begin
`ifdef DFE_CFG_WR_VERIFY_EN
          w_write_nxt = 1'b0;
          w_state_nxt = S_VSETUP;
`else
          w_launch = 1'b1;
`endif
        end else if (RD_LAT == 0) begin
          w_rdata_nxt     = MRDATA;
          w_rsp_valid_nxt = 1'b1;
          w_msel_nxt      = '0;
          w_write_nxt     = 1'b0;
          w_state_nxt     = S_RESP;
        end else begin
          w_lat_nxt   = c_LAT_INIT;
          w_state_nxt = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (r_lat == 2'd0) begin
          w_rdata_nxt     = MRDATA;
          w_rsp_valid_nxt = 1'b1;
          w_msel_nxt      = '0;
          w_write_nxt     = 1'b0;
          w_state_nxt     = S_RESP;
        end else begin
          w_lat_nxt = r_lat - 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_launch        = 1'b1;
        end
      end
`ifdef DFE_CFG_WR_VERIFY_EN
      S_VSETUP: begin
        w_trans_nxt = 1'b1;
        w_state_nxt = S_VACCESS;
      end
      S_VACCESS: begin
        if (RD_LAT == 0) begin
          w_verr_nxt = w_mismatch;
          w_launch   = 1'b1;
        end else begin
          w_lat_nxt   = c_LAT_INIT;
          w_state_nxt = S_VRDWAIT;
        end
      end
      S_VRDWAIT: begin
        if (r_lat == 2'd0) begin
          w_verr_nxt = w_mismatch;
          w_launch   = 1'b1;
        end else begin
          w_lat_nxt = r_lat - 2'd1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    // Start the next queued command; a bad select is dropped with an error pulse instead.
    if (w_launch) begin
      w_state_nxt = S_IDLE;
      w_msel_nxt  = '0;
      w_write_nxt = 1'b0;
      if (!w_empty) begin
        w_pop = 1'b1;
        if (w_head_ok) begin
          w_state_nxt = S_SETUP;
          w_msel_nxt  = w_head_onehot;
          w_addr_nxt  = w_head.addr;
          w_write_nxt = w_head.write;
          w_wdata_nxt = w_head.wdata;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lat       <= 2'd0;
      r_msel      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_trans     <= 1'b0;
      r_err       <= 1'b0;
      r_verr      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lat       <= w_lat_nxt;
      r_msel      <= w_msel_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_write     <= w_write_nxt;
      r_trans     <= w_trans_nxt;
      r_err       <= w_err_nxt;
      r_verr      <= w_verr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign MTRANS    = r_trans;
  assign MWRITE    = r_write;
  assign MSELx     = r_msel;
  assign MADDR     = r_addr;
  assign MWDATA    = r_wdata;
  assign err_sel   = r_err;
  assign busy      = !w_empty || (r_state != S_IDLE);
`ifdef DFE_CFG_WR_VERIFY_EN
  assign verify_err = r_verr;
`else
  logic w_unused_verr;
  assign w_unused_verr = r_verr;
`endif

endmodule

`default_nettype wire
